mem_req_arb: RTL and testbench
==============================

// Module: mem_req_arb
// PURPOSE
//  Shares one memory port (mem_req_o / mem_resp_i) between N LLC-side requesters.
//  Round-robin arbitration on requests; each grant gets a free tag from a tag table.
//  The tag is driven on mem_req_o_bits_idx; responses are routed back to the
//  originating requester with its own idx restored. Sits between LLC slices and the memory model/controller.
// PARAMETERS
//  N          4    number of requesters (2..8)
//  REQ_IDX_W  4    requester-side idx width
//  MEM_IDX_W  5    memory-side tag width; 2**MEM_IDX_W tags outstanding max
//  MCN_W      36   mcn width (mcn_t)
//  PCN_W      36   pcn width (pcn_t)
// PORTS
//  clock               in   1            single clock
//  reset               in   1            asynchronous reset, active-low
//  req_i_valid         in   N            per-requester request valid
//  req_i_ready         out  N            per-requester request accept
//  req_i_bits_idx      in   N*REQ_IDX_W  requester transaction id
//  req_i_bits_rnw      in   N            1=read 0=write
//  req_i_bits_mcn      in   N*MCN_W      machine cache-line number
//  req_i_bits_pcn      in   N*PCN_W      physical cache-line number
//  req_i_bits_data     in   N*512        write data
//  resp_o_valid        out  N            per-requester response valid
//  resp_o_ready        in   N            per-requester response accept
//  resp_o_bits_idx     out  REQ_IDX_W    restored requester idx (shared bus)
//  resp_o_bits_err/rnw out  1/1          copied from memory response
//  resp_o_bits_data    out  512          read data
//  mem_req_o_*         out/in  valid,ready,idx[MEM_IDX_W],rnw,mcn,pcn,data[512]
//  mem_resp_i_*        in/out  valid,ready,idx[MEM_IDX_W],err,rnw,data[512]
//  busy_o              out  MEM_IDX_W+1  count of outstanding tags
//  err_stray_o         out  1            sticky: response carried an unallocated tag
// BEHAVIOUR
//  Reset (reset==0, async): all valids/readies 0, tag table empty, rr pointer 0,
//   busy_o 0, err_stray_o 0; in-flight transactions are discarded.
//  Request path: one output register stage. req_i_ready[i] = grant[i] & tag_free_any
//   & (!mem_req_o_valid | mem_req_o_ready). Handshake at cycle t -> mem_req_o_valid at t+1.
//   mem_req_o_* hold stable while valid & !ready.
//  Arbiter: round-robin starting at rr_ptr; after a handshake from i, rr_ptr = i+1 mod N.
//   No grant while no free tag (all req_i_ready 0).
//  Tag alloc: lowest-numbered free tag, taken from pre-cycle free vector; entry stores
//   {src, req_idx}. A tag freed in cycle t is allocatable from t+1.
//  Response path: one-entry buffer. mem_resp_i_ready = buffer empty | buffer drained this
//   cycle. Captured response drives resp_o_valid[src] at t+1 (only that bit set),
//   resp_o_bits_idx = stored req_idx. Tag freed on resp_o handshake, not on capture.
//  Stray response (tag not allocated): accepted, dropped, err_stray_o set until reset.
//  busy_o: +1 on mem_req_o handshake-side alloc, -1 on resp_o handshake; simultaneous
//   alloc+free leaves it unchanged. Full = busy_o == 2**MEM_IDX_W.
//  Response ordering is whatever memory returns; no reordering inside the block.
// STRUCTURE
//  Package mem_arb_pkg: widths, tag_entry_t {valid, src[$clog2(N)], idx[REQ_IDX_W]},
//   req_t {rnw, mcn, pcn, data}, resp_t.
//  Sub-module rr_arb (N-way round-robin, grant + pointer update) instantiated once;
//   tag table, free-priority encoder and both register stages live in top.
// TESTING
//  Single read from req 2, idx 0x9 -> mem_req_o idx 0, resp tag 0 -> resp_o_valid=4'b0100, idx 0x9, t+1.
//  All 4 requesters valid continuously, mem always ready -> grants 0,1,2,3,0,... one per cycle.
//  Issue 32 reads without responses -> 33rd stalls (req_i_ready 0), busy_o=32; one resp freed -> next issues 1 cycle later with freed tag.
//  mem_req_o_ready low 5 cycles -> mem_req_o_* stable, no further req_i handshake.
//  Response to unallocated tag 7 -> nothing on resp_o, err_stray_o=1 sticky.
//  resp_o_ready low on target while further mem responses arrive -> mem_resp_i_ready 0 after one captured; reset asserted mid-traffic -> all outputs 0 immediately, busy_o 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared widths and record types for the memory request arbiter.
package mem_arb_pkg;

    localparam int DEF_N         = 4;
    localparam int DEF_REQ_IDX_W = 4;
    localparam int DEF_MEM_IDX_W = 5;
    localparam int DEF_MCN_W     = 36;
    localparam int DEF_PCN_W     = 36;
    localparam int DEF_DATA_W    = 512;
    localparam int DEF_SRC_W     = $clog2(DEF_N);

    // One tag-table slot: which requester owns the tag and the idx it used
    typedef struct packed {
        logic                     valid;
        logic [DEF_SRC_W-1:0]     src;
        logic [DEF_REQ_IDX_W-1:0] idx;
    } tag_entry_t;

    // Request payload forwarded to memory
    typedef struct packed {
        logic                  rnw;
        logic [DEF_MCN_W-1:0]  mcn;
        logic [DEF_PCN_W-1:0]  pcn;
        logic [DEF_DATA_W-1:0] data;
    } req_t;

    // Response payload returned to the requester
    typedef struct packed {
        logic                  err;
        logic                  rnw;
        logic [DEF_DATA_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin arbiter: search starts at the pointer, pointer moves past
// the winner only when the winner's request is actually accepted.
module rr_arb #(
    parameter int N = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;

    // Pick the first active request at or after the pointer, wrapping at N
    always_comb begin
        logic             found;
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] j;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        j         = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N))
                sum = sum - (IDX_W+1)'(N);
            j = sum[IDX_W-1:0];
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = j;
            end
        end
    end

    // Pointer moves to the requester after the one just served
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ptr <= '0;
        else if (advance)
            ptr <= (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + IDX_W'(1);
    end

endmodule

// File: rtl/mem_req_arb.sv
// Shares one memory port between N requesters. Each accepted request takes the
// lowest free tag; the tag table maps memory responses back to their owner.
// Struct field widths come from mem_arb_pkg, so parameters must match it.
module mem_req_arb
    import mem_arb_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int REQ_IDX_W = DEF_REQ_IDX_W,
    parameter int MEM_IDX_W = DEF_MEM_IDX_W,
    parameter int MCN_W     = DEF_MCN_W,
    parameter int PCN_W     = DEF_PCN_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N-1:0]            req_i_valid,
    output logic [N-1:0]            req_i_ready,
    input  logic [N*REQ_IDX_W-1:0]  req_i_bits_idx,
    input  logic [N-1:0]            req_i_bits_rnw,
    input  logic [N*MCN_W-1:0]      req_i_bits_mcn,
    input  logic [N*PCN_W-1:0]      req_i_bits_pcn,
    input  logic [N*512-1:0]        req_i_bits_data,
    output logic [N-1:0]            resp_o_valid,
    input  logic [N-1:0]            resp_o_ready,
    output logic [REQ_IDX_W-1:0]    resp_o_bits_idx,
    output logic                    resp_o_bits_err,
    output logic                    resp_o_bits_rnw,
    output logic [511:0]            resp_o_bits_data,
    output logic                    mem_req_o_valid,
    input  logic                    mem_req_o_ready,
    output logic [MEM_IDX_W-1:0]    mem_req_o_bits_idx,
    output logic                    mem_req_o_bits_rnw,
    output logic [MCN_W-1:0]        mem_req_o_bits_mcn,
    output logic [PCN_W-1:0]        mem_req_o_bits_pcn,
    output logic [511:0]            mem_req_o_bits_data,
    input  logic                    mem_resp_i_valid,
    output logic                    mem_resp_i_ready,
    input  logic [MEM_IDX_W-1:0]    mem_resp_i_bits_idx,
    input  logic                    mem_resp_i_bits_err,
    input  logic                    mem_resp_i_bits_rnw,
    input  logic [511:0]            mem_resp_i_bits_data,
    output logic [MEM_IDX_W:0]      busy_o,
    output logic                    err_stray_o
);

    localparam int SRC_W = $clog2(N);
    localparam int NTAGS = 1 << MEM_IDX_W;

    tag_entry_t           tag_table [NTAGS];
    logic [NTAGS-1:0]     tag_free;
    logic [MEM_IDX_W-1:0] alloc_tag;
    logic                 can_issue;
    logic [N-1:0]         grant;
    logic [SRC_W-1:0]     grant_idx;
    logic                 req_hs;

    req_t                 mem_req_q;
    logic                 mem_req_valid_q;
    logic [MEM_IDX_W-1:0] mem_req_idx_q;

    logic                 rb_valid;
    tag_entry_t           rb_entry;
    logic [MEM_IDX_W-1:0] rb_tag;
    resp_t                rb_resp;
    logic                 resp_drain;
    logic                 resp_cap;
    tag_entry_t           cap_entry;

    logic [MEM_IDX_W:0]   busy_q;
    logic                 err_stray_q;

    rr_arb #(.N(N), .IDX_W(SRC_W)) u_rr_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_i_valid),
        .advance   (req_hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Free vector and lowest-numbered free tag, from the registered table
    always_comb begin
        tag_free  = '0;
        alloc_tag = '0;
        for (int t = 0; t < NTAGS; t++)
            tag_free[t] = !tag_table[t].valid;
        for (int t = NTAGS-1; t >= 0; t--)
            if (tag_free[t])
                alloc_tag = MEM_IDX_W'(t);
    end

    // Handshake qualification on both sides; readies held low during reset
    always_comb begin
        can_issue        = (|tag_free) & (!mem_req_valid_q | mem_req_o_ready);
        req_i_ready      = grant & {N{can_issue & reset}};
        req_hs           = |(req_i_valid & req_i_ready);
        resp_drain       = rb_valid & resp_o_ready[rb_entry.src];
        mem_resp_i_ready = reset & (!rb_valid | resp_drain);
        resp_cap         = mem_resp_i_valid & mem_resp_i_ready;
        cap_entry        = tag_table[mem_resp_i_bits_idx];
    end

    // Tag table: allocate on request accept, release on response delivery
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_table <= '{default: '0};
        end else begin
            if (resp_drain)
                tag_table[rb_tag].valid <= 1'b0;
            if (req_hs)
                tag_table[alloc_tag] <= '{valid: 1'b1, src: grant_idx,
                    idx: req_i_bits_idx[grant_idx*REQ_IDX_W +: REQ_IDX_W]};
        end
    end

    // Outstanding-tag counter, net of same-cycle alloc and release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            busy_q <= '0;
        else if (req_hs && !resp_drain)
            busy_q <= busy_q + (MEM_IDX_W+1)'(1);
        else if (!req_hs && resp_drain)
            busy_q <= busy_q - (MEM_IDX_W+1)'(1);
    end

    // Memory request output register, held while memory stalls it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_valid_q <= 1'b0;
            mem_req_idx_q   <= '0;
            mem_req_q       <= '0;
        end else if (req_hs) begin
            mem_req_valid_q <= 1'b1;
            mem_req_idx_q   <= alloc_tag;
            mem_req_q       <= '{rnw:  req_i_bits_rnw[grant_idx],
                                 mcn:  req_i_bits_mcn[grant_idx*MCN_W +: MCN_W],
                                 pcn:  req_i_bits_pcn[grant_idx*PCN_W +: PCN_W],
                                 data: req_i_bits_data[grant_idx*512 +: 512]};
        end else if (mem_req_o_ready) begin
            mem_req_valid_q <= 1'b0;
        end
    end

    // One-entry response buffer; stray tags are swallowed and flagged
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rb_valid    <= 1'b0;
            rb_entry    <= '0;
            rb_tag      <= '0;
            rb_resp     <= '0;
            err_stray_q <= 1'b0;
        end else begin
            if (resp_cap && cap_entry.valid) begin
                rb_valid <= 1'b1;
                rb_entry <= cap_entry;
                rb_tag   <= mem_resp_i_bits_idx;
                rb_resp  <= '{err: mem_resp_i_bits_err, rnw: mem_resp_i_bits_rnw,
                              data: mem_resp_i_bits_data};
            end else if (resp_drain) begin
                rb_valid <= 1'b0;
            end
            if (resp_cap && !cap_entry.valid)
                err_stray_q <= 1'b1;
        end
    end

    // Output fan-out of the registered stages
    always_comb begin
        mem_req_o_valid     = mem_req_valid_q;
        mem_req_o_bits_idx  = mem_req_idx_q;
        mem_req_o_bits_rnw  = mem_req_q.rnw;
        mem_req_o_bits_mcn  = mem_req_q.mcn;
        mem_req_o_bits_pcn  = mem_req_q.pcn;
        mem_req_o_bits_data = mem_req_q.data;
        resp_o_valid        = rb_valid ? (N'(1) << rb_entry.src) : '0;
        resp_o_bits_idx     = rb_entry.idx;
        resp_o_bits_err     = rb_resp.err;
        resp_o_bits_rnw     = rb_resp.rnw;
        resp_o_bits_data    = rb_resp.data;
        busy_o              = busy_q;
        err_stray_o         = err_stray_q;
    end

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: inputs change on the falling edge, outputs
// are sampled 1ns later, well away from the rising edge.
module tb_mem_req_arb;

    localparam int N  = 4;
    localparam int RW = 4;
    localparam int MW = 5;
    localparam int CW = 36;
    localparam int PW = 36;
    localparam int DW = 512;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_i_valid;
    logic [N-1:0]      req_i_ready;
    logic [N*RW-1:0]   req_i_bits_idx;
    logic [N-1:0]      req_i_bits_rnw;
    logic [N*CW-1:0]   req_i_bits_mcn;
    logic [N*PW-1:0]   req_i_bits_pcn;
    logic [N*DW-1:0]   req_i_bits_data;
    logic [N-1:0]      resp_o_valid;
    logic [N-1:0]      resp_o_ready;
    logic [RW-1:0]     resp_o_bits_idx;
    logic              resp_o_bits_err;
    logic              resp_o_bits_rnw;
    logic [DW-1:0]     resp_o_bits_data;
    logic              mem_req_o_valid;
    logic              mem_req_o_ready;
    logic [MW-1:0]     mem_req_o_bits_idx;
    logic              mem_req_o_bits_rnw;
    logic [CW-1:0]     mem_req_o_bits_mcn;
    logic [PW-1:0]     mem_req_o_bits_pcn;
    logic [DW-1:0]     mem_req_o_bits_data;
    logic              mem_resp_i_valid;
    logic              mem_resp_i_ready;
    logic [MW-1:0]     mem_resp_i_bits_idx;
    logic              mem_resp_i_bits_err;
    logic              mem_resp_i_bits_rnw;
    logic [DW-1:0]     mem_resp_i_bits_data;
    logic [MW:0]       busy_o;
    logic              err_stray_o;

    int check_count = 0;
    int fail_count  = 0;

    localparam logic [DW-1:0] DATA_A = {16{32'hDEADBEEF}};
    localparam logic [DW-1:0] DATA_B = {16{32'h0BADF00D}};

    mem_req_arb dut (
        .clock                (clock),
        .reset                (reset),
        .req_i_valid          (req_i_valid),
        .req_i_ready          (req_i_ready),
        .req_i_bits_idx       (req_i_bits_idx),
        .req_i_bits_rnw       (req_i_bits_rnw),
        .req_i_bits_mcn       (req_i_bits_mcn),
        .req_i_bits_pcn       (req_i_bits_pcn),
        .req_i_bits_data      (req_i_bits_data),
        .resp_o_valid         (resp_o_valid),
        .resp_o_ready         (resp_o_ready),
        .resp_o_bits_idx      (resp_o_bits_idx),
        .resp_o_bits_err      (resp_o_bits_err),
        .resp_o_bits_rnw      (resp_o_bits_rnw),
        .resp_o_bits_data     (resp_o_bits_data),
        .mem_req_o_valid      (mem_req_o_valid),
        .mem_req_o_ready      (mem_req_o_ready),
        .mem_req_o_bits_idx   (mem_req_o_bits_idx),
        .mem_req_o_bits_rnw   (mem_req_o_bits_rnw),
        .mem_req_o_bits_mcn   (mem_req_o_bits_mcn),
        .mem_req_o_bits_pcn   (mem_req_o_bits_pcn),
        .mem_req_o_bits_data  (mem_req_o_bits_data),
        .mem_resp_i_valid     (mem_resp_i_valid),
        .mem_resp_i_ready     (mem_resp_i_ready),
        .mem_resp_i_bits_idx  (mem_resp_i_bits_idx),
        .mem_resp_i_bits_err  (mem_resp_i_bits_err),
        .mem_resp_i_bits_rnw  (mem_resp_i_bits_rnw),
        .mem_resp_i_bits_data (mem_resp_i_bits_data),
        .busy_o               (busy_o),
        .err_stray_o          (err_stray_o)
    );

    // Free-running 10ns clock
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one requester slot; pcn and data are derived from mcn
    task automatic applyStimulus(input int src, input logic valid, input logic [RW-1:0] idx,
                                 input logic rnw, input logic [CW-1:0] mcn);
        req_i_valid[src]               = valid;
        req_i_bits_idx[src*RW +: RW]   = idx;
        req_i_bits_rnw[src]            = rnw;
        req_i_bits_mcn[src*CW +: CW]   = mcn;
        req_i_bits_pcn[src*PW +: PW]   = ~mcn;
        req_i_bits_data[src*DW +: DW]  = {16{mcn[31:0]}};
    endtask

    task automatic driveMemResp(input logic valid, input logic [MW-1:0] tag,
                                input logic [DW-1:0] data);
        mem_resp_i_valid     = valid;
        mem_resp_i_bits_idx  = tag;
        mem_resp_i_bits_err  = 1'b0;
        mem_resp_i_bits_rnw  = 1'b1;
        mem_resp_i_bits_data = data;
    endtask

    task automatic doReset();
        reset           = 1'b0;
        req_i_valid     = '0;
        req_i_bits_idx  = '0;
        req_i_bits_rnw  = '0;
        req_i_bits_mcn  = '0;
        req_i_bits_pcn  = '0;
        req_i_bits_data = '0;
        resp_o_ready    = '1;
        mem_req_o_ready = 1'b1;
        driveMemResp(1'b0, '0, '0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        doReset();
        #1;
        checkOutput("rst busy", busy_o, 0);
        checkOutput("rst err_stray", err_stray_o, 0);
        checkOutput("rst resp_valid", resp_o_valid, 0);
        checkOutput("rst mem_req_valid", mem_req_o_valid, 0);

        // Single read from requester 2, idx 0x9, served by tag 0
        @(negedge clock);
        applyStimulus(2, 1'b1, 4'h9, 1'b1, 36'h012345678);
        #1 checkOutput("t1 req_ready", req_i_ready, 4'b0100);
        @(negedge clock);
        applyStimulus(2, 1'b0, 4'h9, 1'b1, 36'h012345678);
        #1;
        checkOutput("t1 mem_valid", mem_req_o_valid, 1);
        checkOutput("t1 mem_idx", mem_req_o_bits_idx, 0);
        checkOutput("t1 mem_rnw", mem_req_o_bits_rnw, 1);
        checkOutput("t1 mem_mcn", mem_req_o_bits_mcn, 36'h012345678);
        checkOutput("t1 busy", busy_o, 1);
        @(negedge clock);
        driveMemResp(1'b1, 5'd0, DATA_A);
        #1;
        checkOutput("t1 mem_valid_clr", mem_req_o_valid, 0);
        checkOutput("t1 mresp_ready", mem_resp_i_ready, 1);
        @(negedge clock);
        driveMemResp(1'b0, 5'd0, '0);
        #1;
        checkOutput("t1 resp_valid", resp_o_valid, 4'b0100);
        checkOutput("t1 resp_idx", resp_o_bits_idx, 4'h9);
        checkOutput("t1 resp_data", resp_o_bits_data, DATA_A);
        @(negedge clock);
        #1;
        checkOutput("t1 resp_done", resp_o_valid, 0);
        checkOutput("t1 busy_done", busy_o, 0);

        // Round robin with all requesters asserting continuously
        doReset();
        for (int i = 0; i < N; i++)
            applyStimulus(i, 1'b1, RW'(i), 1'b1, CW'(36'h100 + i));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            checkOutput($sformatf("rr grant%0d", k), req_i_ready, 4'b0001 << (k % 4));
            if (k > 0) begin
                checkOutput($sformatf("rr mcn%0d", k), mem_req_o_bits_mcn,
                            36'h100 + ((k - 1) % 4));
                checkOutput($sformatf("rr tag%0d", k), mem_req_o_bits_idx, k - 1);
            end
        end
        @(negedge clock);
        for (int i = 0; i < N; i++)
            applyStimulus(i, 1'b0, '0, 1'b0, '0);

        // Exhaust all 32 tags, then free one
        doReset();
        applyStimulus(0, 1'b1, 4'h3, 1'b1, 36'h55);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clock);
            #1 checkOutput($sformatf("full issue%0d", k), req_i_ready, 4'b0001);
        end
        @(negedge clock);
        #1;
        checkOutput("full stall", req_i_ready, 0);
        checkOutput("full busy", busy_o, 32);
        @(negedge clock);
        #1 checkOutput("full stall2", req_i_ready, 0);
        @(negedge clock);
        driveMemResp(1'b1, 5'd5, DATA_B);
        #1 checkOutput("full mresp_ready", mem_resp_i_ready, 1);
        @(negedge clock);
        driveMemResp(1'b0, '0, '0);
        #1;
        checkOutput("full resp_valid", resp_o_valid, 4'b0001);
        checkOutput("full resp_idx", resp_o_bits_idx, 4'h3);
        checkOutput("full still_stall", req_i_ready, 0);
        @(negedge clock);
        #1;
        checkOutput("full reissue", req_i_ready, 4'b0001);
        checkOutput("full busy31", busy_o, 31);
        @(negedge clock);
        applyStimulus(0, 1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("full reuse_valid", mem_req_o_valid, 1);
        checkOutput("full reuse_tag", mem_req_o_bits_idx, 5);
        checkOutput("full busy32", busy_o, 32);

        // Memory back-pressure holds the output stage stable
        doReset();
        mem_req_o_ready = 1'b0;
        applyStimulus(1, 1'b1, 4'h2, 1'b1, 36'hAAA);
        #1 checkOutput("bp req_ready", req_i_ready, 4'b0010);
        @(negedge clock);
        applyStimulus(1, 1'b0, '0, 1'b0, '0);
        applyStimulus(3, 1'b1, 4'hC, 1'b0, 36'hBBB);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            checkOutput($sformatf("bp valid%0d", k), mem_req_o_valid, 1);
            checkOutput($sformatf("bp mcn%0d", k), mem_req_o_bits_mcn, 36'hAAA);
            checkOutput($sformatf("bp tag%0d", k), mem_req_o_bits_idx, 0);
            checkOutput($sformatf("bp blocked%0d", k), req_i_ready, 0);
        end
        @(negedge clock);
        mem_req_o_ready = 1'b1;
        #1;
        checkOutput("bp open", req_i_ready, 4'b1000);
        checkOutput("bp hold_mcn", mem_req_o_bits_mcn, 36'hAAA);
        @(negedge clock);
        applyStimulus(3, 1'b0, 4'hC, 1'b0, 36'hBBB);
        #1;
        checkOutput("bp next_valid", mem_req_o_valid, 1);
        checkOutput("bp next_mcn", mem_req_o_bits_mcn, 36'hBBB);
        checkOutput("bp next_tag", mem_req_o_bits_idx, 1);
        checkOutput("bp next_rnw", mem_req_o_bits_rnw, 0);
        @(negedge clock);
        #1;
        checkOutput("bp drained", mem_req_o_valid, 0);
        checkOutput("bp busy", busy_o, 2);

        // Stray response on unallocated tag 7
        @(negedge clock);
        driveMemResp(1'b1, 5'd7, DATA_A);
        #1 checkOutput("stray accept", mem_resp_i_ready, 1);
        @(negedge clock);
        driveMemResp(1'b0, '0, '0);
        #1;
        checkOutput("stray no_resp", resp_o_valid, 0);
        checkOutput("stray flag", err_stray_o, 1);
        checkOutput("stray busy", busy_o, 2);
        repeat (2) @(negedge clock);
        #1 checkOutput("stray sticky", err_stray_o, 1);

        // Response back-pressure on the target requester
        resp_o_ready = '0;
        @(negedge clock);
        driveMemResp(1'b1, 5'd0, DATA_A);
        #1 checkOutput("rbp first_ready", mem_resp_i_ready, 1);
        @(negedge clock);
        driveMemResp(1'b1, 5'd1, DATA_B);
        #1;
        checkOutput("rbp full", mem_resp_i_ready, 0);
        checkOutput("rbp resp_valid", resp_o_valid, 4'b0010);
        checkOutput("rbp resp_idx", resp_o_bits_idx, 4'h2);
        @(negedge clock);
        #1 checkOutput("rbp still_full", mem_resp_i_ready, 0);
        @(negedge clock);
        resp_o_ready = 4'b0010;
        #1 checkOutput("rbp drain_ready", mem_resp_i_ready, 1);
        @(negedge clock);
        driveMemResp(1'b0, '0, '0);
        resp_o_ready = '0;
        #1;
        checkOutput("rbp second_valid", resp_o_valid, 4'b1000);
        checkOutput("rbp second_idx", resp_o_bits_idx, 4'hC);
        checkOutput("rbp second_data", resp_o_bits_data, DATA_B);
        checkOutput("rbp busy", busy_o, 1);

        // Asynchronous reset in the middle of traffic
        @(negedge clock);
        applyStimulus(0, 1'b1, 4'h1, 1'b1, 36'h77);
        #1 checkOutput("mid req_ready", req_i_ready, 4'b0001);
        #1 reset = 1'b0;
        #1;
        checkOutput("mid resp_valid", resp_o_valid, 0);
        checkOutput("mid req_ready0", req_i_ready, 0);
        checkOutput("mid mresp_ready", mem_resp_i_ready, 0);
        checkOutput("mid mem_valid", mem_req_o_valid, 0);
        checkOutput("mid busy", busy_o, 0);
        checkOutput("mid err_stray", err_stray_o, 0);
        @(negedge clock);
        applyStimulus(0, 1'b0, '0, 1'b0, '0);
        reset = 1'b1;
        #1 checkOutput("mid post_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
